// File: rtl/smag_mac_acc_pkg.sv
// Shared definitions for the sign-magnitude MAC accumulator stage:
// FSM state encodings, the default product width and a saturation helper.
package smag_mac_acc_pkg;

    // Control states; encodings are fixed so they match external debug views.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default product magnitude width, matching the multiplier's m output.
    localparam int PROD_W_DEF = 8;

    // A two's-complement sum one bit wider than the accumulator overflowed
    // exactly when its top two bits disagree.
    function automatic logic sum_overflow(input logic top_bit, input logic next_bit);
        return top_bit ^ next_bit;
    endfunction

endpackage

// File: rtl/smag_to_tc.sv
// Combinational sign-magnitude to two's-complement converter. The magnitude
// is zero-extended to ACC_W and negated when the sign is set; a negative zero
// (m=0, sign=1) yields plain zero.
module smag_to_tc #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [PROD_W-1:0] i_m,
    input  logic              i_sign,
    output logic [ACC_W-1:0]  o_tc
);

    logic [ACC_W-1:0] w_mag;

    assign w_mag = {{(ACC_W-PROD_W){1'b0}}, i_m};

    // Negate non-zero magnitudes with the sign set; everything else passes through.
    always_comb begin
        o_tc = w_mag;
        if (i_sign && (i_m != {PROD_W{1'b0}})) begin
            o_tc = {ACC_W{1'b0}} - w_mag;
        end else begin
            o_tc = w_mag;
        end
    end

endmodule

// File: rtl/smag_mac_acc.sv
// Saturating dot-product accumulator placed after the 4-bit approximate
// sign-magnitude multiplier. Collects N_TERMS products through a valid/ready
// input, accumulates them with clamping, and presents the (optionally ReLU'd)
// result on a valid/ready output.
module smag_mac_acc
    import smag_mac_acc_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 16,
    parameter int RELU_EN = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_prod_valid,
    input  logic [PROD_W-1:0] i_prod_m,
    input  logic              i_prod_sign,
    output logic              o_prod_ready,
    output logic [ACC_W-1:0]  o_acc_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_sat_flag,
    output logic              o_busy
);

    localparam int               CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_sat_flag;
    logic [ACC_W-1:0]  r_acc_out;
    logic              r_out_valid;
    logic              r_prod_ready;
    logic              r_busy;

    logic [ACC_W-1:0]  w_tc;
    logic [ACC_W:0]    w_sum;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_acc_sat;
    logic [ACC_W-1:0]  w_result;
    logic              w_accept;
    logic              w_last;
    logic              w_out_hs;

    smag_to_tc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_to_tc (
        .i_m    (i_prod_m),
        .i_sign (i_prod_sign),
        .o_tc   (w_tc)
    );

    assign w_accept = i_prod_valid & r_prod_ready;
    assign w_last   = w_accept & (r_count == CNT_LAST);
    assign w_out_hs = r_out_valid & i_out_ready;

    // Widen by one bit so the true sum is always representable before clamping.
    assign w_sum = {r_acc[ACC_W-1], r_acc} + {w_tc[ACC_W-1], w_tc};
    assign w_ovf = sum_overflow(w_sum[ACC_W], w_sum[ACC_W-1]);

    // Clamp toward the rail indicated by the true sign of the wide sum.
    always_comb begin
        w_acc_sat = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            w_acc_sat = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            w_acc_sat = w_sum[ACC_W-1:0];
        end
    end

    // Final result: optional ReLU forces negative sums to zero.
    always_comb begin
        w_result = w_acc_sat;
        if ((RELU_EN != 0) && w_acc_sat[ACC_W-1]) begin
            w_result = {ACC_W{1'b0}};
        end else begin
            w_result = w_acc_sat;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_ACC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_DONE: begin
                if (w_out_hs) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and datapath, all driven from the state being left.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc        <= {ACC_W{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_sat_flag   <= 1'b0;
            r_acc_out    <= {ACC_W{1'b0}};
            r_out_valid  <= 1'b0;
            r_prod_ready <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_prod_ready <= (w_state_nxt == ST_ACC);
            r_busy       <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_acc      <= {ACC_W{1'b0}};
                        r_count    <= {CNT_W{1'b0}};
                        r_sat_flag <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_sat;
                        r_count <= r_count + CNT_ONE;
                        if (w_ovf) begin
                            r_sat_flag <= 1'b1;
                        end
                        if (w_last) begin
                            r_acc_out   <= w_result;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_prod_ready = r_prod_ready;
    assign o_acc_out    = r_acc_out;
    assign o_out_valid  = r_out_valid;
    assign o_sat_flag   = r_sat_flag;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_smag_mac_acc.sv
// Directed bench for smag_mac_acc. Three instances share the input stimulus:
// defaults, RELU_EN=1, and a narrow ACC_W=10 accumulator.
module tb_smag_mac_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       prod_valid;
    logic [7:0] prod_m;
    logic       prod_sign;
    logic       out_ready;

    logic        d_ready, d_valid, d_sat, d_busy;
    logic [15:0] d_acc;
    logic        r_ready, r_valid, r_sat, r_busy;
    logic [15:0] r_acc;
    logic        n_ready, n_valid, n_sat, n_busy;
    logic [9:0]  n_acc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    smag_mac_acc u_def (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_prod_valid(prod_valid),
        .i_prod_m(prod_m), .i_prod_sign(prod_sign), .o_prod_ready(d_ready),
        .o_acc_out(d_acc), .o_out_valid(d_valid), .i_out_ready(out_ready),
        .o_sat_flag(d_sat), .o_busy(d_busy)
    );

    smag_mac_acc #(.RELU_EN(1)) u_relu (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_prod_valid(prod_valid),
        .i_prod_m(prod_m), .i_prod_sign(prod_sign), .o_prod_ready(r_ready),
        .o_acc_out(r_acc), .o_out_valid(r_valid), .i_out_ready(out_ready),
        .o_sat_flag(r_sat), .o_busy(r_busy)
    );

    smag_mac_acc #(.ACC_W(10)) u_nar (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_prod_valid(prod_valid),
        .i_prod_m(prod_m), .i_prod_sign(prod_sign), .o_prod_ready(n_ready),
        .o_acc_out(n_acc), .o_out_valid(n_valid), .i_out_ready(out_ready),
        .o_sat_flag(n_sat), .o_busy(n_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] m, input logic s);
        prod_valid = 1'b1;
        prod_m     = m;
        prod_sign  = s;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic start_dp();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_m     = 8'd0;
        prod_sign  = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("rst_acc",   {16'd0, d_acc}, 32'd0);
        chk("rst_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_busy",  {31'd0, d_busy}, 32'd0);
        chk("rst_sat",   {31'd0, d_sat}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'd0, d_ready}, 32'd0);

        // Test 1: alternating +/-10, back-to-back.
        start_dp();
        chk("t1_ready", {31'd0, d_ready}, 32'd1);
        chk("t1_busy",  {31'd0, d_busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            send(8'd10, i[0]);
            if (i == 14) chk("t1_valid_early", {31'd0, d_valid}, 32'd0);
        end
        chk("t1_valid", {31'd0, d_valid}, 32'd1);
        chk("t1_acc",   {16'd0, d_acc}, 32'd0);
        chk("t1_sat",   {31'd0, d_sat}, 32'd0);
        chk("t1_ready_done", {31'd0, d_ready}, 32'd0);
        handshake();
        chk("t1_valid_clr", {31'd0, d_valid}, 32'd0);

        // Tests 2/3: 16 x +225, then 16 x -225.
        start_dp();
        for (int i = 0; i < 16; i++) begin
            send(8'd225, 1'b0);
            if (i == 1) chk("t3_sat_2", {31'd0, n_sat}, 32'd0);
            if (i == 2) chk("t3_sat_3", {31'd0, n_sat}, 32'd1);
        end
        chk("t2_pos_acc",  {16'd0, d_acc}, 32'd3600);
        chk("t2_pos_sat",  {31'd0, d_sat}, 32'd0);
        chk("t2_pos_relu", {16'd0, r_acc}, 32'd3600);
        chk("t3_nar_acc",  {22'd0, n_acc}, 32'd511);
        chk("t3_nar_sat",  {31'd0, n_sat}, 32'd1);
        handshake();
        start_dp();
        chk("t3_sat_clr", {31'd0, n_sat}, 32'd0);
        for (int i = 0; i < 16; i++) send(8'd225, 1'b1);
        chk("t2_neg_acc",  {16'd0, d_acc}, 32'h0000F1F0);
        chk("t2_neg_relu", {16'd0, r_acc}, 32'd0);
        chk("t2_neg_nar",  {22'd0, n_acc}, 32'h00000200);
        chk("t2_neg_nsat", {31'd0, n_sat}, 32'd1);
        handshake();

        // Test 4: negative zeros with a stall after every term.
        start_dp();
        for (int i = 0; i < 16; i++) begin
            send(8'd0, 1'b1);
            if (i < 15) begin
                tick();
                if (i == 14) begin
                    chk("t4_valid_early", {31'd0, d_valid}, 32'd0);
                    chk("t4_ready_gap",   {31'd0, d_ready}, 32'd1);
                end
            end
        end
        chk("t4_valid", {31'd0, d_valid}, 32'd1);
        chk("t4_acc",   {16'd0, d_acc}, 32'd0);
        chk("t4_sat",   {31'd0, d_sat}, 32'd0);
        handshake();

        // Test 5: backpressure in DONE with start and prod_valid pulsed.
        start_dp();
        for (int i = 0; i < 16; i++) send(8'd3, 1'b0);
        chk("t5_acc", {16'd0, d_acc}, 32'd48);
        for (int i = 0; i < 5; i++) begin
            start      = i[0];
            prod_valid = 1'b1;
            prod_m     = 8'd7;
            tick();
        end
        start      = 1'b0;
        prod_valid = 1'b0;
        chk("t5_hold_acc",   {16'd0, d_acc}, 32'd48);
        chk("t5_hold_ready", {31'd0, d_ready}, 32'd0);
        chk("t5_hold_valid", {31'd0, d_valid}, 32'd1);
        chk("t5_hold_busy",  {31'd0, d_busy}, 32'd1);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("t5_hs_valid", {31'd0, d_valid}, 32'd0);
        chk("t5_hs_busy",  {31'd0, d_busy}, 32'd0);
        chk("t5_hs_acc",   {16'd0, d_acc}, 32'd48);
        tick();
        chk("t5_no_restart", {31'd0, d_busy}, 32'd0);

        // Test 6: reset after 7 accepts, then a fresh dot product.
        start_dp();
        for (int i = 0; i < 7; i++) send(8'd5, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_acc",   {16'd0, d_acc}, 32'd0);
        chk("t6_busy",  {31'd0, d_busy}, 32'd0);
        chk("t6_ready", {31'd0, d_ready}, 32'd0);
        chk("t6_valid", {31'd0, d_valid}, 32'd0);
        start_dp();
        for (int i = 0; i < 16; i++) send(8'd1, 1'b0);
        chk("t6_fresh_valid", {31'd0, d_valid}, 32'd1);
        chk("t6_fresh_acc",   {16'd0, d_acc}, 32'd16);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
